// File: rtl/io_pkg.sv
// Shared constants for breadboard input blocks: default clear address,
// status-word bit positions and counter widths.
package io_pkg;

  localparam logic [11:0] CLR_ADDR_DEFAULT = 12'hFFF;

  localparam int EVENT_COUNT_W = 8;
  localparam int DEBOUNCE_W    = 8;

  // Bit positions inside the q_io status word.
  localparam int Q_CLEAN_BIT   = 0;
  localparam int Q_PENDING_BIT = 1;
  localparam int Q_COUNT_LSB   = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit; reusable for
// any breadboard signal that crosses into the processor clock domain.
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // their inputs from the same edge; blocking here would collapse the chain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Synchronizes and debounces a raw breadboard input, flags clean rising edges
// and exposes a status word. INPUT_EVENT_COUNT_EN adds an 8-bit event counter.
module input_conditioner
  import io_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 10,
  parameter logic [11:0] CLR_ADDR        = CLR_ADDR_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        raw_in,
  input  logic        wren,
  input  logic [11:0] address_dmem,
  input  logic [31:0] data,
  output logic        reg15_input,
  output logic        event_pending,
  output logic [31:0] q_io
);

  localparam logic [DEBOUNCE_W-1:0] DEB_MAX = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);

  logic                     sync_in;
  logic [DEBOUNCE_W-1:0]    deb_cnt;
  logic [DEBOUNCE_W-1:0]    deb_cnt_nxt;
  logic                     clean_nxt;
  logic                     rise;
  logic                     clr_hit;
  logic [EVENT_COUNT_W-1:0] event_count;
  logic                     unused_data;

  sync_2ff u_sync (
    .clock (clock),
    .reset (reset),
    .d     (raw_in),
    .q     (sync_in)
  );

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    deb_cnt_nxt = '0;
    clean_nxt   = reg15_input;
    if (sync_in != reg15_input) begin
      if (deb_cnt == DEB_MAX) clean_nxt   = sync_in;
      else                    deb_cnt_nxt = deb_cnt + 1'b1;
    end
  end

  assign rise        = clean_nxt & ~reg15_input;
  assign clr_hit     = wren && (address_dmem == CLR_ADDR) && data[0];
  assign unused_data = ^data[31:1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      deb_cnt       <= '0;
      reg15_input   <= 1'b0;
      event_pending <= 1'b0;
    end else begin
      deb_cnt     <= deb_cnt_nxt;
      reg15_input <= clean_nxt;
      // A new edge outranks a simultaneous software clear so no event is lost.
      if (rise)         event_pending <= 1'b1;
      else if (clr_hit) event_pending <= 1'b0;
    end
  end

`ifdef INPUT_EVENT_COUNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       event_count <= '0;
    else if (rise)    event_count <= event_count + 1'b1;
    else if (clr_hit) event_count <= '0;
  end
`else
  assign event_count = '0;
`endif

  always_comb begin
    q_io                                     = '0;
    q_io[Q_CLEAN_BIT]                        = reg15_input;
    q_io[Q_PENDING_BIT]                      = event_pending;
    q_io[Q_COUNT_LSB +: EVENT_COUNT_W]       = event_count;
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed scenarios plus random
// stimulus against a sample-window reference model.
module tb_input_conditioner;

  localparam int D = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        raw_in = 1'b0;
  logic        wren = 1'b0;
  logic [11:0] address_dmem = '0;
  logic [31:0] data = '0;
  logic        reg15_input;
  logic        event_pending;
  logic [31:0] q_io;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // Reference model: raw values captured at each edge, clean level, flag, count.
  bit       raw_q[$];
  bit       clean_m;
  bit       pend_m;
  bit [7:0] cnt_m;

  input_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .CLR_ADDR        (12'hFFF)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .raw_in        (raw_in),
    .wren          (wren),
    .address_dmem  (address_dmem),
    .data          (data),
    .reg15_input   (reg15_input),
    .event_pending (event_pending),
    .q_io          (q_io)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] q_model();
    return {16'h0000, cnt_m, 6'b000000, pend_m, clean_m};
  endfunction

  task automatic model_reset();
    raw_q.delete();
    repeat (D + 2) raw_q.push_back(1'b0);
    clean_m = 1'b0;
    pend_m  = 1'b0;
    cnt_m   = 8'h00;
  endtask

  // The clean level flips once the last D synchronized samples (raw values
  // captured two edges earlier) all disagree with it.
  task automatic model_edge();
    bit flip;
    bit clr;
    bit rise;
    flip = 1'b1;
    for (int k = 0; k < D; k++)
      if (raw_q[raw_q.size() - 2 - k] == clean_m) flip = 1'b0;
    clr = wren && (address_dmem == 12'hFFF) && data[0];
    raw_q.push_back(raw_in);
    void'(raw_q.pop_front());
    rise = flip && !clean_m;
    if (flip) clean_m = !clean_m;
    if (rise)     pend_m = 1'b1;
    else if (clr) pend_m = 1'b0;
`ifdef INPUT_EVENT_COUNT_EN
    if (rise)     cnt_m = cnt_m + 8'd1;
    else if (clr) cnt_m = 8'h00;
`endif
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clock);
    #1;
    check({tag, ":reg15"}, 32'(reg15_input), 32'(clean_m));
    check({tag, ":pending"}, 32'(event_pending), 32'(pend_m));
    check({tag, ":q_io"}, q_io, q_model());
  endtask

  initial begin
    int len;

    // Reset held with raw_in high: everything must read zero.
    reset  = 1'b0;
    raw_in = 1'b1;
    model_reset();
    #3;
    check("rst_q_io", q_io, 32'h0);
    repeat (3) @(posedge clock);
    #1;
    check("rst_hold_reg15", 32'(reg15_input), 32'h0);
    check("rst_hold_pending", 32'(event_pending), 32'h0);

    // Release: reg15_input low through cycle 11, high at cycle 12.
    reset = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step("latency");
      if (i == 11) check("lat_c11_low", 32'(reg15_input), 32'h0);
      if (i == 12) begin
        check("lat_c12_high", 32'(reg15_input), 32'h1);
        check("lat_c12_pending", 32'(event_pending), 32'h1);
      end
    end
    repeat (5) step("hold_high");

    // Six-cycle low glitch must not disturb the clean level.
    raw_in = 1'b0;
    repeat (6) step("glitch");
    raw_in = 1'b1;
    repeat (12) step("post_glitch");
    check("glitch_reg15", 32'(reg15_input), 32'h1);

    // Software clear of the pending flag.
    wren = 1'b1; address_dmem = 12'hFFF; data = 32'h1;
    step("clear");
    wren = 1'b0;
    check("clear_pending", 32'(event_pending), 32'h0);
    check("clear_q_io", q_io, 32'h00000001);

    // Clean rising edge coincident with a clear write: set wins.
    raw_in = 1'b0;
    repeat (14) step("fall");
    raw_in = 1'b1;
    repeat (11) step("rise_wait");
    wren = 1'b1; address_dmem = 12'hFFF; data = 32'h1;
    step("coincide");
    wren = 1'b0;
    check("coincide_pending", 32'(event_pending), 32'h1);
`ifdef INPUT_EVENT_COUNT_EN
    check("coincide_q_io", q_io, 32'h00000103);
`else
    check("coincide_q_io", q_io, 32'h00000003);
`endif

    // Writes that must be ignored.
    wren = 1'b1; address_dmem = 12'hFFF; data = 32'hFFFF_FFFE;
    step("nop_data0");
    address_dmem = 12'h123; data = 32'h1;
    step("nop_addr");
    address_dmem = 12'hFFE;
    step("nop_addr2");
    wren = 1'b0;
    check("nop_pending", 32'(event_pending), 32'h1);

    // Reset asserted mid-debounce (counter at 7) clears everything at once.
    raw_in = 1'b0;
    repeat (14) step("pre_abort_fall");
    raw_in = 1'b1;
    repeat (9) step("abort_count");
    #2;
    reset = 1'b0;
    #1;
    check("abort_q_io", q_io, 32'h0);
    check("abort_reg15", 32'(reg15_input), 32'h0);
    check("abort_pending", 32'(event_pending), 32'h0);
    model_reset();
    #2;
    reset = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step("abort_relat");
      if (i == 11) check("abort_c11_low", 32'(reg15_input), 32'h0);
      if (i == 12) check("abort_c12_high", 32'(reg15_input), 32'h1);
    end

    // 256 clean pulses after a clear: the event count wraps back to zero.
    raw_in = 1'b0;
    repeat (14) step("wrap_settle");
    wren = 1'b1; address_dmem = 12'hFFF; data = 32'h1;
    step("wrap_clear");
    wren = 1'b0;
    for (int p = 0; p < 256; p++) begin
      raw_in = 1'b1;
      repeat (D + 3) step("wrap_hi");
      raw_in = 1'b0;
      repeat (D + 3) step("wrap_lo");
    end
    check("wrap_count", 32'(q_io[15:8]), 32'h0);
    check("wrap_pending", 32'(event_pending), 32'h1);

    // Random levels, glitches and bus writes against the model.
    repeat (60) begin
      raw_in = 1'($urandom % 2);
      len = $urandom_range(1, 2 * D);
      repeat (len) begin
        wren         = ($urandom % 5) == 0;
        address_dmem = ($urandom % 2 == 0) ? 12'hFFF : 12'($urandom);
        data         = $urandom;
        step("random");
      end
    end
    wren = 1'b0;
    check("random_upper_zero", 32'(q_io[31:16]), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 10, is the number of consecutive stable synchronized samples required before the clean level changes; legal range is 1..255.
REQ-002 Parameter CLR_ADDR, default 12'hFFF, is the data-memory address whose write acts on this block.
REQ-003 Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port raw_in, input, 1 bit: asynchronous external input (button or breadboard signal).
REQ-006 Port wren, input, 1 bit: processor data-memory write enable.
REQ-007 Port address_dmem, input, 12 bits: processor data-memory address.
REQ-008 Port data, input, 32 bits: processor data-memory write data.
REQ-009 Port reg15_input, output, 1 bit: debounced clean level, driven to the register-file r15 input.
REQ-010 Port event_pending, output, 1 bit: sticky flag set by a clean rising edge.
REQ-011 Port q_io, output, 32 bits: status word {event_count[7:0] in bits 15:8, event_pending in bit 1, reg15_input in bit 0}; all other bits zero.

Function
REQ-012 raw_in shall pass through a two-flop synchronizer; sync_in is the second flop.
REQ-013 A counter (8 bits wide) shall reset to 0 whenever sync_in equals reg15_input, and shall otherwise increment by 1 per cycle.
REQ-014 When the counter reaches DEBOUNCE_CYCLES-1 while sync_in still differs from reg15_input, reg15_input shall take sync_in on the next edge and the counter shall return to 0.
REQ-015 Total latency from a clean raw_in step to reg15_input is 2 + DEBOUNCE_CYCLES cycles.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles shall not change reg15_input.
REQ-017 The counter shall never exceed DEBOUNCE_CYCLES-1, so it never wraps.
REQ-018 A 0->1 transition of reg15_input shall set event_pending on the same edge that reg15_input rises.
REQ-019 A cycle with wren=1, address_dmem==CLR_ADDR and data[0]=1 shall clear event_pending on the next edge.
REQ-020 When a set and a clear occur in the same cycle, set shall win and event_pending shall remain 1.
REQ-021 A write to CLR_ADDR with data[0]=0, or any write to another address, shall have no effect.
REQ-022 q_io shall be combinational from registered state, with no added latency.

Reset
REQ-023 While reset=0, all synchronizer flops, the counter, reg15_input, event_pending and event_count shall be 0, asynchronously.
REQ-024 Reset asserted during a debounce shall abandon it; after release, the block requires a full 2 + DEBOUNCE_CYCLES cycles of stable high input before reg15_input goes high.

Configuration
REQ-025 Macro INPUT_EVENT_COUNT_EN defined: an 8-bit event_count shall increment on every clean rising edge, wrap from 255 to 0, be cleared by the REQ-019 write, and increment (not clear) when the increment and the clear coincide.
REQ-026 Macro INPUT_EVENT_COUNT_EN undefined: no counter register exists and q_io[15:8] shall read 0.

Structure
REQ-027 Shared package io_pkg shall hold the default CLR_ADDR constant, the q_io bit-position constants and the event-count width.
REQ-028 The synchronizer shall be a sub-module named sync_2ff (clock, reset, d, q), reusable for other breadboard inputs.

Verification
REQ-029 Reset=0 with raw_in=1, then release: reg15_input stays 0 for 11 cycles and is 1 at cycle 12 (DEBOUNCE_CYCLES=10); event_pending=1 from the same edge.
REQ-030 Hold raw_in=1, then pulse it low for 6 cycles: reg15_input stays 1 throughout and the counter returns to 0.
REQ-031 Write data=1 to address 12'hFFF while event_pending=1: event_pending=0 next cycle and q_io=32'h00000001.
REQ-032 Make a clean rising edge coincide with a clear write: event_pending stays 1; with the macro defined, event_count increments by 1.
REQ-033 Macro defined, 256 clean pulses: event_count wraps to 0 and q_io[15:8]=8'h00; with the macro undefined, q_io[15:8] is always 0.
REQ-034 Assert reset at debounce counter value 7: all outputs are 0 immediately, without waiting for a clock edge.
